id_ex_reg: RTL and testbench

Pipeline register between the decode/bypass stage and the execute stage of the five-stage MIPS core. Captures decoded control, the forwarded operands produced by the decode-stage bypass unit, and the immediate. It turns the load-use lock into a single-cycle bubble, kills the decode slot on a redirect, and holds under a global stall. A two-state machine freezes the pipeline after a halting syscall.

---
 rtl/id_ex_reg.sv | 197 +++++++++++++++++++
 tb/tb_id_ex_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: bubble on load-use lock, kill on redirect, hold on stall, freeze after halting syscall.
// Optional performance counters (bubble_cnt, flush_cnt) are built only when PERF_CNT_EN is defined.
module id_ex_reg #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          nop_lock_id,
    input  logic          valid_id,
    input  logic [DW-1:0] pc_id,
    input  logic [DW-1:0] instr_id,
    input  logic [DW-1:0] bypass_data1_id,
    input  logic [DW-1:0] bypass_data2_id,
    input  logic [DW-1:0] imm_id,
    input  logic [RW-1:0] regfile_write_num_id,
    input  logic          RegWrite_id,
    input  logic          MemRead_id,
    input  logic          MemWrite_id,
    input  logic          MemToReg_id,
    input  logic          ALUSrc_id,
    input  logic [3:0]    ALUOp_id,
    input  logic [1:0]    Jump_id,
    input  logic          syscall_halt_id,
    output logic          valid_id_ex,
    output logic [DW-1:0] pc_id_ex,
    output logic [DW-1:0] instr_id_ex,
    output logic [DW-1:0] bypass_data1_id_ex,
    output logic [DW-1:0] bypass_data2_id_ex,
    output logic [DW-1:0] imm_id_ex,
    output logic [RW-1:0] regfile_write_num_id_ex,
    output logic          RegWrite_id_ex,
    output logic          MemRead_id_ex,
    output logic          MemWrite_id_ex,
    output logic          MemToReg_id_ex,
    output logic          ALUSrc_id_ex,
    output logic [3:0]    ALUOp_id_ex,
    output logic [1:0]    Jump_id_ex,
    output logic          syscall_halt_id_ex,
`ifdef PERF_CNT_EN
    output logic          halted,
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   flush_cnt
`else
    output logic          halted
`endif
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] pc_q, pc_d, instr_q, instr_d;
    logic [DW-1:0] bp1_q, bp1_d, bp2_q, bp2_d, imm_q, imm_d;
    logic [RW-1:0] wnum_q, wnum_d;
    logic          rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
    logic          m2r_q, m2r_d, alusrc_q, alusrc_d, sys_q, sys_d;
    logic [3:0]    aluop_q, aluop_d;
    logic [1:0]    jump_q, jump_d;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        bp1_d    = bp1_q;
        bp2_d    = bp2_q;
        imm_d    = imm_q;
        wnum_d   = wnum_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        m2r_d    = m2r_q;
        alusrc_d = alusrc_q;
        aluop_d  = aluop_q;
        jump_d   = jump_q;
        sys_d    = sys_q;
        if (state_q == HALTED) begin
            // Frozen: keep issuing bubbles, data fields stay put.
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
            sys_d   = 1'b0;
            jump_d  = 2'b00;
        end else if (!stall) begin
            valid_d  = valid_id;
            pc_d     = pc_id;
            instr_d  = instr_id;
            bp1_d    = bypass_data1_id;
            bp2_d    = bypass_data2_id;
            imm_d    = imm_id;
            wnum_d   = regfile_write_num_id;
            rw_d     = RegWrite_id;
            mr_d     = MemRead_id;
            mw_d     = MemWrite_id;
            m2r_d    = MemToReg_id;
            alusrc_d = ALUSrc_id;
            aluop_d  = ALUOp_id;
            jump_d   = Jump_id;
            sys_d    = syscall_halt_id;
            if (flush || nop_lock_id) begin
                valid_d = 1'b0;
                rw_d    = 1'b0;
                mr_d    = 1'b0;
                mw_d    = 1'b0;
                sys_d   = 1'b0;
                jump_d  = 2'b00;
            end
            if (flush)
                instr_d = '0;
            if (valid_id && !flush && !nop_lock_id && syscall_halt_id)
                state_d = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            bp1_q    <= '0;
            bp2_q    <= '0;
            imm_q    <= '0;
            wnum_q   <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            alusrc_q <= 1'b0;
            aluop_q  <= '0;
            jump_q   <= '0;
            sys_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            bp1_q    <= bp1_d;
            bp2_q    <= bp2_d;
            imm_q    <= imm_d;
            wnum_q   <= wnum_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            m2r_q    <= m2r_d;
            alusrc_q <= alusrc_d;
            aluop_q  <= aluop_d;
            jump_q   <= jump_d;
            sys_q    <= sys_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;
    logic        cap_en, bubble_inc, flush_inc;

    // A flush that coincides with a lock is charged to flush only.
    assign cap_en     = (state_q == RUN) && !stall;
    assign bubble_inc = cap_en && !flush && nop_lock_id;
    assign flush_inc  = cap_en && flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_q + {31'd0, bubble_inc};
            flush_cnt_q  <= flush_cnt_q + {31'd0, flush_inc};
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

    assign valid_id_ex             = valid_q;
    assign pc_id_ex                = pc_q;
    assign instr_id_ex             = instr_q;
    assign bypass_data1_id_ex      = bp1_q;
    assign bypass_data2_id_ex      = bp2_q;
    assign imm_id_ex               = imm_q;
    assign regfile_write_num_id_ex = wnum_q;
    assign RegWrite_id_ex          = rw_q;
    assign MemRead_id_ex           = mr_q;
    assign MemWrite_id_ex          = mw_q;
    assign MemToReg_id_ex          = m2r_q;
    assign ALUSrc_id_ex            = alusrc_q;
    assign ALUOp_id_ex             = aluop_q;
    assign Jump_id_ex              = jump_q;
    assign syscall_halt_id_ex      = sys_q;
    assign halted                  = (state_q == HALTED);

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed table-driven bench for id_ex_reg; data operands are derived from pc so holds and captures are checkable.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, nop_lock_id, valid_id;
    logic [31:0] pc_id, instr_id, bypass_data1_id, bypass_data2_id, imm_id;
    logic [4:0]  regfile_write_num_id;
    logic        RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id, ALUSrc_id;
    logic [3:0]  ALUOp_id;
    logic [1:0]  Jump_id;
    logic        syscall_halt_id;
    logic        valid_id_ex;
    logic [31:0] pc_id_ex, instr_id_ex, bypass_data1_id_ex, bypass_data2_id_ex, imm_id_ex;
    logic [4:0]  regfile_write_num_id_ex;
    logic        RegWrite_id_ex, MemRead_id_ex, MemWrite_id_ex, MemToReg_id_ex, ALUSrc_id_ex;
    logic [3:0]  ALUOp_id_ex;
    logic [1:0]  Jump_id_ex;
    logic        syscall_halt_id_ex, halted;
`ifdef PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .nop_lock_id(nop_lock_id),
        .valid_id(valid_id), .pc_id(pc_id), .instr_id(instr_id),
        .bypass_data1_id(bypass_data1_id), .bypass_data2_id(bypass_data2_id), .imm_id(imm_id),
        .regfile_write_num_id(regfile_write_num_id), .RegWrite_id(RegWrite_id),
        .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id), .MemToReg_id(MemToReg_id),
        .ALUSrc_id(ALUSrc_id), .ALUOp_id(ALUOp_id), .Jump_id(Jump_id),
        .syscall_halt_id(syscall_halt_id),
        .valid_id_ex(valid_id_ex), .pc_id_ex(pc_id_ex), .instr_id_ex(instr_id_ex),
        .bypass_data1_id_ex(bypass_data1_id_ex), .bypass_data2_id_ex(bypass_data2_id_ex),
        .imm_id_ex(imm_id_ex), .regfile_write_num_id_ex(regfile_write_num_id_ex),
        .RegWrite_id_ex(RegWrite_id_ex), .MemRead_id_ex(MemRead_id_ex),
        .MemWrite_id_ex(MemWrite_id_ex), .MemToReg_id_ex(MemToReg_id_ex),
        .ALUSrc_id_ex(ALUSrc_id_ex), .ALUOp_id_ex(ALUOp_id_ex), .Jump_id_ex(Jump_id_ex),
        .syscall_halt_id_ex(syscall_halt_id_ex),
`ifdef PERF_CNT_EN
        .halted(halted), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`else
        .halted(halted)
`endif
    );

    // sc = {rst, stall, flush, lock, valid}; cin/eo = {RegWrite, MemRead, MemWrite, Jump[1:0], halt}
    typedef struct {
        string       name;
        logic [4:0]  sc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  cin;
        logic        ev;
        logic [5:0]  eo;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        ehalt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(logic [4:0] sc, logic [31:0] pc, logic [31:0] instr, logic [5:0] cin);
        {rst, stall, flush, nop_lock_id, valid_id} = sc;
        pc_id                = pc;
        instr_id             = instr;
        bypass_data1_id      = pc ^ 32'hA5A5_0000;
        bypass_data2_id      = ~pc;
        imm_id               = {pc[15:0], pc[31:16]};
        regfile_write_num_id = pc[6:2];
        ALUOp_id             = pc[5:2];
        MemToReg_id          = pc[2];
        ALUSrc_id            = pc[3];
        {RegWrite_id, MemRead_id, MemWrite_id, Jump_id, syscall_halt_id} = cin;
    endtask

    task automatic add(string n, logic [4:0] sc, logic [31:0] pc, logic [31:0] instr, logic [5:0] cin,
                       logic ev, logic [5:0] eo, logic [31:0] epc, logic [31:0] einstr, logic eh);
        vec_t v;
        v.name = n; v.sc = sc; v.pc = pc; v.instr = instr; v.cin = cin;
        v.ev = ev; v.eo = eo; v.epc = epc; v.einstr = einstr; v.ehalt = eh;
        vecs.push_back(v);
    endtask

    task automatic check_row(vec_t v);
        logic        z;
        logic [31:0] p;
        z = (v.epc == 32'd0);
        p = v.epc;
        chk({v.name, ".valid"}, {31'd0, valid_id_ex}, {31'd0, v.ev});
        chk({v.name, ".ctrl"}, {26'd0, RegWrite_id_ex, MemRead_id_ex, MemWrite_id_ex, Jump_id_ex,
                                syscall_halt_id_ex}, {26'd0, v.eo});
        chk({v.name, ".pc"}, pc_id_ex, p);
        chk({v.name, ".instr"}, instr_id_ex, v.einstr);
        chk({v.name, ".bp1"}, bypass_data1_id_ex, z ? 32'd0 : p ^ 32'hA5A5_0000);
        chk({v.name, ".bp2"}, bypass_data2_id_ex, z ? 32'd0 : ~p);
        chk({v.name, ".imm"}, imm_id_ex, {p[15:0], p[31:16]});
        chk({v.name, ".misc"}, {19'd0, regfile_write_num_id_ex, ALUOp_id_ex, MemToReg_id_ex, ALUSrc_id_ex},
            {19'd0, p[6:2], p[5:2], p[2], p[3]});
        chk({v.name, ".halted"}, {31'd0, halted}, {31'd0, v.ehalt});
    endtask

    initial begin
        //   name        {r,s,f,l,v}  pc            instr         cin        ev  eo         epc           einstr        halt
        add("rst0",     5'b10001, 32'h0000_1234, 32'hDEAD_BEEF, 6'b111111, 0, 6'b000000, 32'h0,        32'h0,        0);
        add("rst1",     5'b10001, 32'h0000_5678, 32'hDEAD_BEEF, 6'b110110, 0, 6'b000000, 32'h0,        32'h0,        0);
        add("lw",       5'b00001, 32'h0040_0000, 32'h8C22_0004, 6'b110000, 1, 6'b110000, 32'h0040_0000, 32'h8C22_0004, 0);
        add("lock",     5'b00011, 32'h0040_0004, 32'h0043_0820, 6'b100100, 0, 6'b000000, 32'h0040_0004, 32'h0043_0820, 0);
        add("after",    5'b00001, 32'h0040_0008, 32'h0043_0820, 6'b100010, 1, 6'b100010, 32'h0040_0008, 32'h0043_0820, 0);
        add("flk",      5'b00111, 32'h0040_000C, 32'h1234_5678, 6'b101110, 0, 6'b000000, 32'h0040_000C, 32'h0,        0);
        add("sw",       5'b00001, 32'h0040_0010, 32'hAC22_0008, 6'b001000, 1, 6'b001000, 32'h0040_0010, 32'hAC22_0008, 0);
        add("stf1",     5'b01101, 32'h0040_0014, 32'hFFFF_FFFF, 6'b111110, 1, 6'b001000, 32'h0040_0010, 32'hAC22_0008, 0);
        add("stf2",     5'b01101, 32'h0040_0014, 32'hFFFF_FFFF, 6'b111110, 1, 6'b001000, 32'h0040_0010, 32'hAC22_0008, 0);
        add("stf3",     5'b01101, 32'h0040_0014, 32'hFFFF_FFFF, 6'b111110, 1, 6'b001000, 32'h0040_0010, 32'hAC22_0008, 0);
        add("stl",      5'b01011, 32'h0040_0014, 32'hFFFF_FFFF, 6'b111111, 1, 6'b001000, 32'h0040_0010, 32'hAC22_0008, 0);
        add("killsys",  5'b00101, 32'h0040_0018, 32'h0000_000C, 6'b100001, 0, 6'b000000, 32'h0040_0018, 32'h0,        0);
        add("deadsys",  5'b00000, 32'h0040_001C, 32'h0000_000C, 6'b100001, 0, 6'b100001, 32'h0040_001C, 32'h0000_000C, 0);
        add("sys",      5'b00001, 32'h0040_0020, 32'h0000_000C, 6'b100001, 1, 6'b100001, 32'h0040_0020, 32'h0000_000C, 1);
        add("hold1",    5'b00001, 32'h0040_0024, 32'h8C22_0004, 6'b110010, 0, 6'b000000, 32'h0040_0020, 32'h0000_000C, 1);
        add("hold2",    5'b01001, 32'h0040_0028, 32'h8C22_0004, 6'b110010, 0, 6'b000000, 32'h0040_0020, 32'h0000_000C, 1);
        add("hold3",    5'b00101, 32'h0040_002C, 32'h8C22_0004, 6'b110010, 0, 6'b000000, 32'h0040_0020, 32'h0000_000C, 1);
        add("rsthalt",  5'b10001, 32'h0040_0030, 32'h8C22_0004, 6'b110010, 0, 6'b000000, 32'h0,        32'h0,        0);
        add("resume",   5'b00001, 32'h0040_0034, 32'h8C22_0004, 6'b010000, 1, 6'b010000, 32'h0040_0034, 32'h8C22_0004, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].sc, vecs[i].pc, vecs[i].instr, vecs[i].cin);
            @(negedge clk);
            check_row(vecs[i]);
        end

`ifdef PERF_CNT_EN
        // Counter corner cases: reset, bubble, flush+lock, stall, halted, wrap.
        drive(5'b10000, 32'h0, 32'h0, 6'b0); @(negedge clk);
        chk("cnt.rst.b", bubble_cnt, 32'd0);
        chk("cnt.rst.f", flush_cnt, 32'd0);
        drive(5'b00011, 32'h100, 32'h0, 6'b100000); @(negedge clk);
        chk("cnt.lock.b", bubble_cnt, 32'd1);
        chk("cnt.lock.f", flush_cnt, 32'd0);
        drive(5'b00111, 32'h104, 32'h0, 6'b100000); @(negedge clk);
        chk("cnt.fl.b", bubble_cnt, 32'd1);
        chk("cnt.fl.f", flush_cnt, 32'd1);
        drive(5'b01111, 32'h108, 32'h0, 6'b100000); @(negedge clk); @(negedge clk);
        chk("cnt.stall.b", bubble_cnt, 32'd1);
        chk("cnt.stall.f", flush_cnt, 32'd1);
        drive(5'b00011, 32'h10C, 32'h0, 6'b0);
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #2 release dut.bubble_cnt_q;
        @(negedge clk);
        chk("cnt.wrap", bubble_cnt, 32'd0);
        drive(5'b00001, 32'h110, 32'h0000_000C, 6'b000001); @(negedge clk);
        drive(5'b00111, 32'h114, 32'h0, 6'b0); @(negedge clk);
        chk("cnt.halt.b", bubble_cnt, 32'd0);
        chk("cnt.halt.f", flush_cnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
